// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice.
// Holds the data-memory size encoding used on the aligner interface, the
// store-buffer entry field widths and entry type, and a lane extraction helper
// used by store-to-load forwarding.
// Optional feature macro: STORE_BUF_FWD_EN (the helper is used only when it is defined).
package store_buffer_pkg;

  // Access size encoding shared with the data aligner.
  localparam logic [1:0] DM_NONE  = 2'b00;
  localparam logic [1:0] DM_BYTE  = 2'b01;
  localparam logic [1:0] DM_HWORD = 2'b10;
  localparam logic [1:0] DM_WORD  = 2'b11;

  // Store-buffer entry field widths.
  localparam int unsigned SB_WADDR_W = 30;
  localparam int unsigned SB_OFF_W   = 2;
  localparam int unsigned SB_DATA_W  = 32;
  localparam int unsigned SB_SIZE_W  = 2;

  typedef struct packed {
    logic                  valid;
    logic [SB_WADDR_W-1:0] waddr;
    logic [SB_OFF_W-1:0]   off;
    logic [SB_DATA_W-1:0]  data;
    logic [SB_SIZE_W-1:0]  size;
  } sb_entry_t;

  // Little-endian lane extraction with optional sign extension; offset 0 = bits [7:0].
  function automatic logic [31:0] sb_extract(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      DM_BYTE:  return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      DM_HWORD: return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Per-entry word-address comparator with youngest-match priority select.
// Ports:
//   valid_i      per-slot entry valid bits
//   waddr_i      per-slot stored word addresses
//   head_i       slot index of the oldest entry
//   load_waddr_i word address of the incoming load
//   hit_o        at least one valid entry matches
//   idx_o        slot index of the youngest matching entry
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [DEPTH-1:0][SB_WADDR_W-1:0] waddr_i,
  input  logic [PTR_W-1:0]                 head_i,
  input  logic [SB_WADDR_W-1:0]            load_waddr_i,
  output logic                             hit_o,
  output logic [PTR_W-1:0]                 idx_o
);

  logic [PTR_W-1:0] slot;

  // Walk slots oldest to youngest; the last match seen is the youngest.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PTR_W'(k);
      if (valid_i[slot] && (waddr_i[slot] == load_waddr_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the execute stage and the data aligner.
// Stores are queued in a circular FIFO and drained one per cycle whenever no
// accepted load owns the port. Loads pass through combinationally with priority;
// a load whose word matches a pending store stalls until that store drains.
// Optional feature macro: STORE_BUF_FWD_EN -- forward word stores to matching loads.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               execute-stage request (address, data, sizes, sign control)
//   req_ready           request accepted this cycle
//   load_data           load result
//   mem_*               aligner interface (address, write data, sizes, sign control)
//   mem_rdata           aligner read result
//   empty               no pending stores
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_write_status,
  input  logic [1:0]  req_read_status,
  input  logic        req_load_signed,
  output logic        req_ready,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_write_status,
  output logic [1:0]  mem_read_status,
  output logic        mem_load_signed,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][SB_WADDR_W-1:0] ent_waddr;
  logic                             match_hit;
  logic [PTR_W-1:0]                 match_idx;

  logic is_load, is_store, full, fwd_hit, load_port, load_stall, enq, deq;
  logic unused_idx;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k] = ent_q[k].valid;
      ent_waddr[k] = ent_q[k].waddr;
    end
  end

  store_buffer_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .valid_i     (ent_valid),
    .waddr_i     (ent_waddr),
    .head_i      (head_q),
    .load_waddr_i(req_addr[31:2]),
    .hit_o       (match_hit),
    .idx_o       (match_idx)
  );

  assign unused_idx = ^match_idx;

  always_comb begin
    // A request carrying both sizes is a load; its write half is ignored.
    is_load  = req_valid && (req_read_status != DM_NONE);
    is_store = req_valid && (req_write_status != DM_NONE) && (req_read_status == DM_NONE);
    full     = (count_q == CNT_W'(DEPTH));
`ifdef STORE_BUF_FWD_EN
    fwd_hit  = is_load && match_hit && (ent_q[match_idx].size == DM_WORD);
`else
    fwd_hit  = 1'b0;
`endif
    load_port  = is_load && !match_hit;
    load_stall = is_load && match_hit && !fwd_hit;
    // Full stalls the store even if a drain frees a slot on the same edge.
    enq = is_store && !full;
    deq = !load_port && (count_q != '0);

    if (!rst_n) begin
      req_ready = 1'b0;
    end else if (is_load) begin
      req_ready = !load_stall;
    end else if (is_store) begin
      req_ready = !full;
    end else begin
      req_ready = 1'b1;
    end

    mem_addr         = '0;
    mem_wdata        = '0;
    mem_write_status = DM_NONE;
    mem_read_status  = DM_NONE;
    mem_load_signed  = 1'b0;
    if (rst_n) begin
      if (load_port) begin
        mem_addr        = req_addr;
        mem_read_status = req_read_status;
        mem_load_signed = req_load_signed;
      end else if (deq) begin
        mem_addr         = {ent_q[head_q].waddr, ent_q[head_q].off};
        mem_wdata        = ent_q[head_q].data;
        mem_write_status = ent_q[head_q].size;
      end
    end

    load_data = mem_rdata;
`ifdef STORE_BUF_FWD_EN
    if (fwd_hit) begin
      load_data = sb_extract(ent_q[match_idx].data, req_addr[1:0], req_read_status,
                             req_load_signed);
    end
`endif

    empty = (count_q == '0);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (enq) begin
      ent_d[tail_q] = '{valid: 1'b1, waddr: req_addr[31:2], off: req_addr[1:0],
                        data: req_data, size: req_write_status};
      tail_d = tail_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer; a queue-based reference model of the
// pending stores predicts every cycle's handshake and aligner-port outputs.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_write_status = '0;
  logic [1:0]  req_read_status = '0;
  logic        req_load_signed = 1'b0;
  logic        req_ready;
  logic [31:0] load_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_write_status;
  logic [1:0]  mem_read_status;
  logic        mem_load_signed;
  logic [31:0] mem_rdata = '0;
  logic        empty;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_write_status(req_write_status),
    .req_read_status (req_read_status),
    .req_load_signed (req_load_signed),
    .req_ready       (req_ready),
    .load_data       (load_data),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_write_status(mem_write_status),
    .mem_read_status (mem_read_status),
    .mem_load_signed (mem_load_signed),
    .mem_rdata       (mem_rdata),
    .empty           (empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t q[$];
  st_t e_new;
  int  n_vec = 0;
  int  n_err = 0;

  logic        e_ready, e_empty, e_enq, e_drain, e_acc_load, e_sgn;
  logic [31:0] e_ld, e_maddr, e_wdata;
  logic [1:0]  e_ws, e_rs;

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    v = word >> (8 * off);
    if (size == 2'b01) begin
      v = v & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b10) begin
      v = v & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Drive one request and predict this cycle's outputs from the pending-store queue.
  task automatic apply(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] ws, input logic [1:0] rs, input logic sg);
    logic ld, st, hit, fwd;
    int   yi;
    req_valid = v; req_addr = a; req_data = d;
    req_write_status = ws; req_read_status = rs; req_load_signed = sg;
    mem_rdata = $urandom;
    ld  = v && (rs != 2'b00);
    st  = v && (ws != 2'b00) && (rs == 2'b00);
    hit = 1'b0;
    yi  = 0;
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) begin hit = 1'b1; yi = i; end
    fwd = 1'b0;
`ifdef STORE_BUF_FWD_EN
    fwd = ld && hit && (q[yi].size == 2'b11);
`endif
    e_acc_load = ld && (!hit || fwd);
    e_ready = ld ? (!hit || fwd) : (st ? (q.size() < DEPTH) : 1'b1);
    e_enq   = st && (q.size() < DEPTH);
    e_drain = !(ld && !hit) && (q.size() > 0);
    e_empty = (q.size() == 0);
    e_ws = 2'b00; e_rs = 2'b00; e_maddr = '0; e_wdata = '0; e_sgn = 1'b0;
    if (ld && !hit) begin
      e_rs = rs; e_maddr = a; e_sgn = sg;
    end else if (e_drain) begin
      e_ws = q[0].size; e_maddr = q[0].addr; e_wdata = q[0].data;
    end
    e_ld = fwd ? ref_load(q[yi].data, a[1:0], rs, sg) : mem_rdata;
    e_new = '{addr: a, data: d, size: ws};
    #3;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (e_drain) void'(q.pop_front());
    if (e_enq) q.push_back(e_new);
  endtask

  task automatic test_reset();
    #2;
    req_valid = 1'b1; req_addr = 32'h0010_0000; req_read_status = 2'b11;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", req_ready); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_vec++; if (mem_read_status !== 2'b00) begin n_err++; $display("FAIL reset_rs got %b want 00", mem_read_status); end
    n_vec++; if (mem_write_status !== 2'b00) begin n_err++; $display("FAIL reset_ws got %b want 00", mem_write_status); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 1'b0; req_read_status = 2'b00;
  endtask

  task automatic test_single_store();
    apply(1'b1, 32'h0010_0004, 32'hDEAD_BEEF, 2'b11, 2'b00, 1'b0);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL store_ready got %b want 1", req_ready); end
    advance();
    apply(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL store_pending got %b want 0", empty); end
    n_vec++; if (mem_write_status !== 2'b11) begin n_err++; $display("FAIL drain_ws got %b want 11", mem_write_status); end
    n_vec++; if (mem_addr !== 32'h0010_0004) begin n_err++; $display("FAIL drain_addr got %h want 00100004", mem_addr); end
    n_vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL drain_data got %h want deadbeef", mem_wdata); end
    advance();
    apply(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drained_empty got %b want 1", empty); end
    n_vec++; if (mem_write_status !== 2'b00) begin n_err++; $display("FAIL idle_ws got %b want 00", mem_write_status); end
    advance();
  endtask

  task automatic test_load_hazard();
    apply(1'b1, 32'h0010_0001, 32'h0000_007F, 2'b01, 2'b00, 1'b0);
    advance();
    apply(1'b1, 32'h0010_0000, 32'h0, 2'b00, 2'b11, 1'b0);
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL hazard_stall got %b want 0", req_ready); end
    n_vec++; if (mem_write_status !== 2'b01) begin n_err++; $display("FAIL hazard_drain_ws got %b want 01", mem_write_status); end
    n_vec++; if (mem_addr !== 32'h0010_0001) begin n_err++; $display("FAIL hazard_drain_addr got %h want 00100001", mem_addr); end
    n_vec++; if (mem_wdata !== 32'h0000_007F) begin n_err++; $display("FAIL hazard_drain_data got %h want 7f", mem_wdata); end
    advance();
    apply(1'b1, 32'h0010_0000, 32'h0, 2'b00, 2'b11, 1'b0);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL hazard_accept got %b want 1", req_ready); end
    n_vec++; if (mem_read_status !== 2'b11) begin n_err++; $display("FAIL hazard_rs got %b want 11", mem_read_status); end
    n_vec++; if (mem_write_status !== 2'b00) begin n_err++; $display("FAIL hazard_ws got %b want 00", mem_write_status); end
    n_vec++; if (load_data !== e_ld) begin n_err++; $display("FAIL hazard_load got %h want %h", load_data, e_ld); end
    advance();
  endtask

  task automatic test_forward();
    logic [31:0] la[3];
    logic [1:0]  lr[3];
    logic        ls[3];
    la[0] = 32'h0010_000B; lr[0] = 2'b01; ls[0] = 1'b1;
    la[1] = 32'h0010_000B; lr[1] = 2'b01; ls[1] = 1'b1;
    la[2] = 32'h0010_0008; lr[2] = 2'b10; ls[2] = 1'b0;
    apply(1'b1, 32'h0010_0008, 32'h8000_0001, 2'b11, 2'b00, 1'b0);
    advance();
`ifdef STORE_BUF_FWD_EN
    apply(1'b1, la[0], 32'h0, 2'b00, lr[0], ls[0]);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready got %b want 1", req_ready); end
    n_vec++; if (load_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL fwd_byte got %h want ffffff80", load_data); end
    n_vec++; if (mem_write_status !== 2'b11) begin n_err++; $display("FAIL fwd_drain_ws got %b want 11", mem_write_status); end
    advance();
`endif
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, la[i], 32'h0, 2'b00, lr[i], ls[i]);
      n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL fwd_seq_ready[%0d] got %b want %b", i, req_ready, e_ready); end
      n_vec++; if (mem_write_status !== e_ws) begin n_err++; $display("FAIL fwd_seq_ws[%0d] got %b want %b", i, mem_write_status, e_ws); end
      if (e_acc_load) begin
        n_vec++; if (load_data !== e_ld) begin n_err++; $display("FAIL fwd_seq_ld[%0d] got %h want %h", i, load_data, e_ld); end
      end
      advance();
    end
  endtask

  // Stores interleaved with non-matching loads: loads hold the port, stores still drain.
  task automatic test_interleave();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) apply(1'b1, 32'h0010_0000 + 32'(4 * i), $urandom, 2'b11, 2'b00, 1'b0);
      else apply(1'b1, 32'h0020_0000, 32'h0, 2'b00, 2'b11, 1'b0);
      n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL ilv_ready[%0d] got %b want %b", i, req_ready, e_ready); end
      n_vec++; if (mem_write_status !== e_ws) begin n_err++; $display("FAIL ilv_ws[%0d] got %b want %b", i, mem_write_status, e_ws); end
      n_vec++; if (mem_addr !== e_maddr) begin n_err++; $display("FAIL ilv_addr[%0d] got %h want %h", i, mem_addr, e_maddr); end
      advance();
    end
    apply(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 32'h0030_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b11, 2'b00, 1'b0);
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, req_ready); end
      if (i > 0) begin
        n_vec++; if (mem_write_status !== 2'b11) begin n_err++; $display("FAIL b2b_ws[%0d] got %b want 11", i, mem_write_status); end
        n_vec++; if (mem_wdata !== 32'hA000_0000 + 32'(i - 1)) begin n_err++; $display("FAIL b2b_order[%0d] got %h want %h", i, mem_wdata, 32'hA000_0000 + 32'(i - 1)); end
        n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL b2b_empty[%0d] got %b want 0", i, empty); end
      end
      advance();
    end
    apply(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    n_vec++; if (mem_wdata !== 32'hA000_0013) begin n_err++; $display("FAIL b2b_last got %h want a0000013", mem_wdata); end
    advance();
  endtask

  task automatic test_reset_mid_drain();
    apply(1'b1, 32'h0040_0000, 32'h1234_5678, 2'b11, 2'b00, 1'b0);
    advance();
    apply(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    n_vec++; if (mem_write_status !== 2'b11) begin n_err++; $display("FAIL mid_drain_ws got %b want 11", mem_write_status); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_reset_empty got %b want 1", empty); end
    n_vec++; if (mem_write_status !== 2'b00) begin n_err++; $display("FAIL mid_reset_ws got %b want 00", mem_write_status); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready got %b want 0", req_ready); end
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
      n_vec++; if (mem_write_status !== 2'b00) begin n_err++; $display("FAIL post_reset_ws[%0d] got %b want 00", i, mem_write_status); end
      advance();
    end
  endtask

  task automatic test_random();
    logic        v, sg;
    logic [1:0]  ws, rs;
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      a  = 32'h0010_0000 + 32'($urandom_range(0, 15));
      ws = 2'($urandom);
      rs = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
      sg = 1'($urandom);
      apply(v, a, $urandom, ws, rs, sg);
      n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, req_ready, e_ready); end
      n_vec++; if (empty !== e_empty) begin n_err++; $display("FAIL rnd_empty[%0d] got %b want %b", i, empty, e_empty); end
      n_vec++; if (mem_write_status !== e_ws) begin n_err++; $display("FAIL rnd_ws[%0d] got %b want %b", i, mem_write_status, e_ws); end
      n_vec++; if (mem_read_status !== e_rs) begin n_err++; $display("FAIL rnd_rs[%0d] got %b want %b", i, mem_read_status, e_rs); end
      if ((e_ws != 2'b00) || (e_rs != 2'b00)) begin
        n_vec++; if (mem_addr !== e_maddr) begin n_err++; $display("FAIL rnd_addr[%0d] got %h want %h", i, mem_addr, e_maddr); end
      end
      if (e_ws != 2'b00) begin
        n_vec++; if (mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, mem_wdata, e_wdata); end
      end
      if (e_rs != 2'b00) begin
        n_vec++; if (mem_load_signed !== e_sgn) begin n_err++; $display("FAIL rnd_sgn[%0d] got %b want %b", i, mem_load_signed, e_sgn); end
      end
      if (e_acc_load) begin
        n_vec++; if (load_data !== e_ld) begin n_err++; $display("FAIL rnd_ld[%0d] got %h want %h", i, load_data, e_ld); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_load_hazard();
    test_forward();
    test_interleave();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
